// File: rtl/seq_pkg.sv
// Shared sequence-block types: FSM states and the default serial pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    GAP_WAIT = 2'd2
  } seq_state_e;

  localparam int          DEF_PAT_W   = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_shifter.sv
// Parallel-load, MSB-first shift register; shifts in zeros so the
// serial output naturally returns to 0 once the word is drained.
module pattern_shifter #(
  parameter int           W    = 4,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic clk_c,
  input  logic reset_r,
  input  logic clr_i,
  input  logic load_i,
  input  logic shift_i,
  output logic msb_o
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clr_i) begin
      sh_d = '0;
    end else if (load_i) begin
      sh_d = INIT;
    end else if (shift_i) begin
      sh_d = sh_q << 1;
    end
  end

  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_o = sh_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Burst transmitter: sends PATTERN MSB-first reps_i times with GAP idle
// cycles between repetitions, then pulses done_o.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               REP_W   = 4,
  parameter int               GAP     = 1
) (
  input  logic             clk_c,
  input  logic             reset_r,
  input  logic             start_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic             abort_i,
  output logic             q_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [REP_W-1:0] ONE_REP  = REP_W'(1);
  localparam bit               NO_GAP   = (GAP == 0);

  seq_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sh_clr, sh_load, sh_shift;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sh_clr   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start_i && reps_i != '0 && !abort_i) begin
          state_d = SEND;
          rep_d   = reps_i;
          bit_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          sh_load = 1'b1;
        end
      end
      SEND: begin
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          rep_d   = '0;
          sh_clr  = 1'b1;
        end else if (bit_q == LAST_BIT) begin
          bit_d = '0;
          if (rep_q == ONE_REP) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rep_d   = '0;
            sh_clr  = 1'b1;
          end else begin
            rep_d = rep_q - 1'b1;
            if (NO_GAP) begin
              sh_load = 1'b1;
            end else begin
              state_d = GAP_WAIT;
              valid_d = 1'b0;
              gap_d   = '0;
              sh_clr  = 1'b1;
            end
          end
        end else begin
          sh_shift = 1'b1;
          bit_d    = bit_q + 1'b1;
        end
      end
      GAP_WAIT: begin
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          rep_d   = '0;
          sh_clr  = 1'b1;
        end else if (gap_q == LAST_GAP) begin
          state_d = SEND;
          bit_d   = '0;
          valid_d = 1'b1;
          sh_load = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        sh_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      state_q <= IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  pattern_shifter #(
    .W    (PAT_W),
    .INIT (PATTERN)
  ) u_shifter (
    .clk_c   (clk_c),
    .reset_r (reset_r),
    .clr_i   (sh_clr),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .msb_o   (q_o)
  );

  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them for two DUT configurations.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_a, st_a, ab_a, rst_b, st_b, ab_b;
  logic [3:0] reps_a, reps_b;
  logic       q_a, v_a, b_a, d_a;
  logic       q_b, v_b, b_b, d_b;

  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];
  string      name_a = "reset";
  string      name_b = "reset";
  int         checks = 0;
  int         errors = 0;

  localparam logic [3:0] IDL = 4'b0000;
  localparam logic [3:0] DNE = 4'b0001;
  localparam logic [3:0] GP  = 4'b0010;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .PAT_W(4), .PATTERN(4'b1011), .REP_W(4), .GAP(1)
  ) dut_a (
    .clk_c(clk), .reset_r(rst_a), .start_i(st_a), .reps_i(reps_a),
    .abort_i(ab_a), .q_o(q_a), .valid_o(v_a), .busy_o(b_a), .done_o(d_a)
  );

  seq_pattern_tx #(
    .PAT_W(4), .PATTERN(4'b1011), .REP_W(4), .GAP(0)
  ) dut_b (
    .clk_c(clk), .reset_r(rst_b), .start_i(st_b), .reps_i(reps_b),
    .abort_i(ab_b), .q_o(q_b), .valid_o(v_b), .busy_o(b_b), .done_o(d_b)
  );

  // monitor: outputs packed as {valid, q, busy, done}
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      if ({v_a, q_a, b_a, d_a} !== e) begin
        errors++;
        $display("FAIL gap1/%s t=%0t got vqbd=%b want %b",
                 name_a, $time, {v_a, q_a, b_a, d_a}, e);
      end
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if ({v_b, q_b, b_b, d_b} !== e) begin
        errors++;
        $display("FAIL gap0/%s t=%0t got vqbd=%b want %b",
                 name_b, $time, {v_b, q_b, b_b, d_b}, e);
      end
    end
  end

  // one cycle: expected outputs of this cycle, inputs for the next edge
  task automatic tick(input bit sel, input logic st, input logic [3:0] rp,
                      input logic ab, input logic rs, input logic [3:0] e);
    if (!sel) begin
      st_a = st; reps_a = rp; ab_a = ab; rst_a = rs;
      exp_a.push_back(e);
    end else begin
      st_b = st; reps_b = rp; ab_b = ab; rst_b = rs;
      exp_b.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] bitv(input int i);
    logic [3:0] pat;
    pat = 4'b1011;
    return {1'b1, pat[3 - (i % 4)], 1'b1, 1'b0};
  endfunction

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) tick(sel, 0, 4'd0, 0, 0, IDL);
  endtask

  initial begin
    rst_a = 1; st_a = 0; ab_a = 0; reps_a = 0;
    rst_b = 1; st_b = 0; ab_b = 0; reps_b = 0;
    repeat (2) @(posedge clk);
    #1;
    tick(0, 0, 4'd0, 0, 1, IDL);
    tick(1, 0, 4'd0, 0, 1, IDL);
    idle(0, 2);
    idle(1, 2);

    name_a = "single_rep";
    tick(0, 1, 4'd1, 0, 0, IDL);
    for (int i = 0; i < 4; i++) tick(0, 0, 4'd0, 0, 0, bitv(i));
    tick(0, 0, 4'd0, 0, 0, DNE);
    idle(0, 2);

    name_a = "two_reps_gap";
    tick(0, 1, 4'd2, 0, 0, IDL);
    for (int i = 0; i < 4; i++) tick(0, 0, 4'd0, 0, 0, bitv(i));
    tick(0, 0, 4'd0, 0, 0, GP);
    for (int i = 0; i < 4; i++) tick(0, 0, 4'd0, 0, 0, bitv(i));
    tick(0, 0, 4'd0, 0, 0, DNE);
    idle(0, 2);

    name_b = "three_reps_b2b";
    tick(1, 1, 4'd3, 0, 0, IDL);
    for (int i = 0; i < 12; i++) tick(1, 0, 4'd0, 0, 0, bitv(i));
    tick(1, 0, 4'd0, 0, 0, DNE);
    idle(1, 2);

    name_a = "abort";
    tick(0, 1, 4'd2, 0, 0, IDL);
    tick(0, 0, 4'd0, 0, 0, bitv(0));
    tick(0, 0, 4'd0, 0, 0, bitv(1));
    tick(0, 0, 4'd0, 1, 0, bitv(2));
    idle(0, 8);

    name_a = "abort_in_gap";
    tick(0, 1, 4'd2, 0, 0, IDL);
    for (int i = 0; i < 4; i++) tick(0, 0, 4'd0, 0, 0, bitv(i));
    tick(0, 0, 4'd0, 1, 0, GP);
    idle(0, 6);

    name_a = "restart_ignored";
    tick(0, 1, 4'd1, 0, 0, IDL);
    tick(0, 0, 4'd0, 0, 0, bitv(0));
    tick(0, 1, 4'd5, 0, 0, bitv(1));
    tick(0, 0, 4'd0, 0, 0, bitv(2));
    tick(0, 0, 4'd0, 0, 0, bitv(3));
    name_a = "start_in_done";
    tick(0, 1, 4'd1, 0, 0, DNE);
    for (int i = 0; i < 4; i++) tick(0, 0, 4'd0, 0, 0, bitv(i));
    tick(0, 0, 4'd0, 0, 0, DNE);
    idle(0, 1);

    name_a = "reps_zero";
    tick(0, 1, 4'd0, 0, 0, IDL);
    idle(0, 6);

    name_a = "abort_wins";
    tick(0, 1, 4'd2, 1, 0, IDL);
    idle(0, 6);

    name_a = "reset_mid";
    tick(0, 1, 4'd2, 0, 0, IDL);
    tick(0, 0, 4'd0, 0, 0, bitv(0));
    tick(0, 0, 4'd0, 0, 1, bitv(1));
    idle(0, 12);

    name_b = "reps_max";
    tick(1, 1, 4'd15, 0, 0, IDL);
    for (int i = 0; i < 60; i++) tick(1, 0, 4'd0, 0, 0, bitv(i));
    tick(1, 0, 4'd0, 0, 0, DNE);
    idle(1, 3);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d left want 0",
               exp_a.size(), exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
